fib_pair_serializer: RTL and testbench
======================================

// Module: fib_pair_serializer
// PURPOSE
// - Downstream stage of the two-per-cycle Fibonacci generator.
// - Accepts one pair of words per handshake: in_a is the earlier term, in_b the later one.
// - Emits the words one per cycle, in sequence order, over a valid/ready stream.
// - Buffers in a small FIFO and flags 2^W wrap-around of the sequence.
// PARAMETERS
// - W      16  data word width (fib_pkg::FIB_W)
// - DEPTH   4  FIFO depth in words; power of two, >= 2
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       asynchronous, active-high reset
// - in_valid   in   1       pair {in_a, in_b} is valid
// - in_ready   out  1       pair can be accepted this cycle
// - in_a       in   W       earlier term of the pair
// - in_b       in   W       later term of the pair
// - out_valid  out  1       out_data is valid
// - out_ready  in   1       consumer takes out_data
// - out_data   out  W       serialized Fibonacci word
// - out_cnt    out  16      number of words emitted, mod 2^16
// - wrap_flag  out  1       sticky: an emitted word was < the previous emitted word
// - seq_err    out  1       sticky sequence error (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async assert, synchronous deassert at clk):
//   - FIFO empty; out_valid=0, out_data=0, out_cnt=0, wrap_flag=0, seq_err=0.
//   - in_ready=1 once reset is released.
// - Mid-operation reset: buffered words are discarded; out_valid drops in the same cycle.
// - Accept condition: in_valid && in_ready.
//   - in_ready = (DEPTH - occupancy) >= 2, from registered occupancy; no dependency on out_ready.
//   - Write order: in_a, then in_b. A pair is never split.
// - Read: out_valid = (occupancy != 0). out_data = FIFO head.
//   - Pops when out_valid && out_ready.
//   - out_data holds stable while out_valid && !out_ready.
// - Latency: a pair accepted at edge N shows in_a on out_data after edge N; in_b follows after the pop.
// - Same-cycle push and pop: occupancy += 2 - 1. Occupancy never exceeds DEPTH and never goes below 0.
// - Pointers: log2(DEPTH) bits, natural wrap; occupancy is log2(DEPTH)+1 bits.
// - On each pop:
//   - out_cnt increments, wrapping 0xFFFF -> 0.
//   - Previous emitted word is registered in prev1; the one before it in prev2.
//   - wrap_flag sets if a word < prev1, skipping the first word after reset.
//   - wrap_flag clears only on rst.
// - Arithmetic is mod 2^W; no saturation.
// - No state machine beyond the FIFO; the handshake is fully determined by occupancy.
// CONFIGURATION
// - Macro: FIB_PAIR_SERIALIZER_SEQ_CHECK_EN
//   - Defined: each popped word from the 3rd onward is compared with (prev1 + prev2) mod 2^W.
//     - A mismatch sets seq_err on the edge after the pop; it is sticky until rst.
//     - Uses one W-bit adder and comparator.
//   - Undefined: seq_err is tied to 0 and the adder/comparator are not generated.
//   - All other behaviour is identical in both builds.
// STRUCTURE
// - fib_pkg: FIB_W=16, typedef logic [FIB_W-1:0] fib_word_t, DEPTH default constant.
// - Sub-module fib_word_fifo:
//   - Parameterized W/DEPTH; 2-write / 1-read FIFO with occupancy output and async reset.
//   - Top level adds the handshake, counter, wrap monitor and sequence checker.
// TESTING
// - out_ready=1, drive pairs (1,1),(2,3),(5,8) -> out_data 1,1,2,3,5,8 on consecutive cycles.
//   - in_ready deasserts once occupancy reaches 3; no word is lost or reordered.
// - out_ready=0, push (1,1),(2,3) -> occupancy 4, in_ready=0, out_data held at 1.
//   - Then out_ready=1 -> 1,1,2,3 drain and in_ready returns when occupancy <= 2.
// - Drive (28657,46368),(9489,55857) -> wrap_flag rises after 9489 pops; stays 1 to end of test.
// - Define FIB_PAIR_SERIALIZER_SEQ_CHECK_EN, drive (1,1),(2,3),(5,9) -> seq_err=1 after 9 pops.
//   - Without the macro, seq_err stays 0.
// - Occupancy 3, assert rst between edges -> out_valid=0 immediately.
//   - After release: in_ready=1, out_cnt=0, flags 0.
// - Random valid/ready backpressure for 10k cycles vs. a reference queue.
//   - Exact order required; out_cnt == pops mod 2^16.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared word type and default sizing for the Fibonacci pair serializer.
package fib_pkg;
  localparam int unsigned FIB_W     = 16;
  localparam int unsigned FIB_DEPTH = 4;
  typedef logic [FIB_W-1:0] fib_word_t;
endpackage

// File: rtl/fib_pair_serializer_if.sv
// Pair-in / word-out stream bundle plus status outputs of fib_pair_serializer.
interface fib_pair_serializer_if
  import fib_pkg::*;
#(
  parameter int unsigned W = FIB_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [15:0]  out_cnt;
  logic         wrap_flag;
  logic         seq_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, wrap_flag, seq_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_cnt, wrap_flag, seq_err
  );
endinterface

// File: rtl/fib_word_fifo.sv
// Two-write / one-read word FIFO with registered occupancy; callers guard push/pop.
module fib_word_fifo
  import fib_pkg::*;
#(
  parameter  int unsigned W     = FIB_W,
  parameter  int unsigned DEPTH = FIB_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_a,
  input  logic [W-1:0] wr_b,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic [PW:0]  occ
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]          <= wr_a;
      mem[wr_ptr + PW'(1)] <= wr_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(2);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + (push ? (PW+1)'(2) : '0) - (pop ? (PW+1)'(1) : '0);
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/fib_pair_serializer.sv
// Serializes Fibonacci word pairs into a one-word stream with wrap monitoring.
// Optional sequence checker enabled by FIB_PAIR_SERIALIZER_SEQ_CHECK_EN.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int unsigned W     = FIB_W,
  parameter int unsigned DEPTH = FIB_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  fib_pair_serializer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]  occ;
  logic [W-1:0] head;
  logic         ready;
  logic         valid;
  logic         push;
  logic         pop;
  logic [15:0]  cnt;
  logic         wrap;
  logic [W-1:0] prev1;
  logic [1:0]   seen;

  assign ready = occ <= (PW+1)'(DEPTH - 2);
  assign valid = occ != '0;
  assign push  = bus.in_valid && ready;
  assign pop   = valid && bus.out_ready;

  fib_word_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_a    (bus.in_a),
    .wr_b    (bus.in_b),
    .pop     (pop),
    .rd_data (head),
    .occ     (occ)
  );

  // seen saturates at 2: "a previous word exists" and "two previous words exist"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      wrap  <= 1'b0;
      prev1 <= '0;
      seen  <= '0;
    end else if (pop) begin
      cnt   <= cnt + 16'd1;
      prev1 <= head;
      if (seen != 2'd0 && head < prev1) wrap <= 1'b1;
      if (seen != 2'd2) seen <= seen + 2'd1;
    end
  end

`ifdef FIB_PAIR_SERIALIZER_SEQ_CHECK_EN
  logic [W-1:0] prev2;
  logic         seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev2 <= '0;
      seq   <= 1'b0;
    end else if (pop) begin
      prev2 <= prev1;
      if (seen == 2'd2 && head != prev1 + prev2) seq <= 1'b1;
    end
  end

  assign bus.seq_err = seq;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? head : '0;
  assign bus.out_cnt   = cnt;
  assign bus.wrap_flag = wrap;
endmodule

// File: tb/tb_fib_pair_serializer.sv
// Self-checking bench for fib_pair_serializer against a queue-based stream model.
module tb_fib_pair_serializer;
  import fib_pkg::*;

  localparam int unsigned DEPTH = FIB_DEPTH;

  logic clk = 1'b0;
  logic rst;

  fib_pair_serializer_if #(.W(16)) bus ();

  fib_pair_serializer #(.W(16), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] q[$];
  logic [15:0] pend_a[$];
  logic [15:0] pend_b[$];
  int          npops;
  logic [15:0] p1, p2;
  logic        exp_wrap, exp_seq;
  bit          gate;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend_a.delete();
    pend_b.delete();
    npops    = 0;
    p1       = '0;
    p2       = '0;
    exp_wrap = 1'b0;
    exp_seq  = 1'b0;
  endtask

  task automatic add_pair(input logic [15:0] a, input logic [15:0] b);
    pend_a.push_back(a);
    pend_b.push_back(b);
  endtask

  // One clock: drive, compare against the model, advance the model by the stream rules.
  task automatic cyc();
    bit          acc;
    bit          pop;
    logic [15:0] w;
    bus.in_valid = gate && pend_a.size() != 0;
    if (pend_a.size() != 0) begin
      bus.in_a = pend_a[0];
      bus.in_b = pend_b[0];
    end
    chk("in_ready",  32'(bus.in_ready),  32'(int'(DEPTH) - q.size() >= 2));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("out_data",  32'(bus.out_data),  32'(q.size() != 0 ? q[0] : 16'h0));
    chk("out_cnt",   32'(bus.out_cnt),   32'(npops % 65536));
    chk("wrap_flag", 32'(bus.wrap_flag), 32'(exp_wrap));
    chk("seq_err",   32'(bus.seq_err),   32'(exp_seq));
    acc = bus.in_valid && (int'(DEPTH) - q.size() >= 2);
    pop = q.size() != 0 && bus.out_ready;
    @(posedge clk);
    #1;
    if (pop) begin
      w = q.pop_front();
      if (npops > 0 && w < p1) exp_wrap = 1'b1;
`ifdef FIB_PAIR_SERIALIZER_SEQ_CHECK_EN
      if (npops >= 2 && w != 16'(p1 + p2)) exp_seq = 1'b1;
`endif
      p2 = p1;
      p1 = w;
      npops++;
    end
    if (acc) begin
      q.push_back(pend_a.pop_front());
      q.push_back(pend_b.pop_front());
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    gate = 1'b1;
    bus.out_ready = 1'b1;
    while ((pend_a.size() != 0 || q.size() != 0) && n < limit) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(n < limit), 32'd1);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    gate = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
    chk("rst_wrap",      32'(bus.wrap_flag), 32'd0);
    chk("rst_seq",       32'(bus.seq_err),   32'd0);
    model_clear();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    gate = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Streaming pairs with a ready consumer
    add_pair(16'd1, 16'd1);
    add_pair(16'd2, 16'd3);
    add_pair(16'd5, 16'd8);
    drain(50);
    chk("t1_cnt", 32'(bus.out_cnt), 32'd6);
    do_reset();

    // Full FIFO under backpressure, then drain
    gate = 1'b1;
    bus.out_ready = 1'b0;
    add_pair(16'd1, 16'd1);
    add_pair(16'd2, 16'd3);
    cyc();
    cyc();
    cyc();
    chk("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_hold_data",     32'(bus.out_data), 32'd1);
    drain(50);
    chk("t2_cnt", 32'(bus.out_cnt), 32'd4);
    do_reset();

    // Sequence break in the third pair
    add_pair(16'd1, 16'd1);
    add_pair(16'd2, 16'd3);
    add_pair(16'd5, 16'd9);
    drain(50);
`ifdef FIB_PAIR_SERIALIZER_SEQ_CHECK_EN
    chk("t3_seq_err", 32'(bus.seq_err), 32'd1);
`else
    chk("t3_seq_err", 32'(bus.seq_err), 32'd0);
`endif
    chk("t3_no_wrap", 32'(bus.wrap_flag), 32'd0);

    // Occupancy 3 then reset mid-cycle
    gate = 1'b1;
    bus.out_ready = 1'b0;
    add_pair(16'd13, 16'd21);
    add_pair(16'd34, 16'd55);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    gate = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    chk("t4_occ3_valid", 32'(bus.out_valid), 32'd1);
    do_reset();
    cyc();

    // 16-bit wrap of the sequence
    add_pair(16'd28657, 16'd46368);
    add_pair(16'd9489,  16'd55857);
    drain(50);
    chk("t5_wrap", 32'(bus.wrap_flag), 32'd1);

    // Random traffic and backpressure
    for (int i = 0; i < 10000; i++) begin
      if (pend_a.size() == 0) add_pair(16'($urandom), 16'($urandom));
      gate = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      cyc();
    end
    drain(100);
    chk("t6_wrap_sticky", 32'(bus.wrap_flag), 32'd1);
    chk("t6_cnt", 32'(bus.out_cnt), 32'(npops % 65536));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
